// File: rtl/vend_pkg.sv
// vend_pkg: shared definitions for the coin vending transaction controller.
// Holds product prices, product index names, payout coin denominations,
// FSM state encodings and the greedy coin-selection helper.
package vend_pkg;

  localparam int N_PROD_DEF  = 6;
  localparam int CNT_W_DEF   = 3;
  localparam int MONEY_W_DEF = 8;

  localparam int PROD_COLA    = 0;
  localparam int PROD_PEPSI   = 1;
  localparam int PROD_SITRO   = 2;
  localparam int PROD_MILK    = 3;
  localparam int PROD_WATER   = 4;
  localparam int PROD_TOMATOS = 5;

  // Product i's price sits at PRICE[i] (index 0 is the rightmost entry).
  localparam logic [5:0][7:0] PRICE = {8'd35, 8'd10, 8'd25, 8'd20, 8'd15, 8'd15};

  localparam logic [7:0] COIN_20 = 8'd20;
  localparam logic [7:0] COIN_10 = 8'd10;
  localparam logic [7:0] COIN_5  = 8'd5;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DISPENSE = 2'd1,
    ST_PAYOUT   = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    PS_IDLE = 2'd0,
    PS_REQ  = 2'd1,
    PS_GAP  = 2'd2
  } pay_state_e;

  // Largest payout coin not exceeding the remaining credit (0 if below 5).
  function automatic logic [7:0] greedy_coin(input logic [7:0] credit);
    if (credit >= COIN_20)      return COIN_20;
    else if (credit >= COIN_10) return COIN_10;
    else if (credit >= COIN_5)  return COIN_5;
    else                        return 8'd0;
  endfunction

endpackage

// File: rtl/vend_payout_seq.sv
// vend_payout_seq: greedy change payout sequencer.
// Started by the main FSM; repeatedly requests the largest coin that fits the
// remaining credit, waiting for pay_ack_i each time, until credit < 5.
// Ports:
//   clk_i, rst_i   clock / asynchronous active-high reset
//   start_i        one-cycle start pulse from the main FSM
//   credit_i       current credit (owned and updated by the main FSM)
//   pay_ack_i      payout mechanism done pulse
//   pay_req_o      coin payout request
//   pay_coin_o     coin value being requested
//   paid_o         coin accepted this cycle; main FSM subtracts pay_coin_o
//   done_o         sequence finished (credit below smallest coin)
//   timeout_o      pay_ack_i never arrived; sequence abandoned
module vend_payout_seq
  import vend_pkg::*;
#(
  parameter int MONEY_W     = MONEY_W_DEF,
  parameter int ACK_TIMEOUT = 63
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [MONEY_W-1:0] credit_i,
  input  logic               pay_ack_i,
  output logic               pay_req_o,
  output logic [MONEY_W-1:0] pay_coin_o,
  output logic               paid_o,
  output logic               done_o,
  output logic               timeout_o
);

  localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);

  pay_state_e         state_q, state_d;
  logic               req_q, req_d;
  logic [MONEY_W-1:0] coin_q, coin_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [MONEY_W-1:0] next_coin;

  assign next_coin = MONEY_W'(greedy_coin(8'(credit_i)));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= PS_IDLE;
      req_q   <= 1'b0;
      coin_q  <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      coin_q  <= coin_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    coin_d    = coin_q;
    timer_d   = timer_q;
    paid_o    = 1'b0;
    done_o    = 1'b0;
    timeout_o = 1'b0;
    unique case (state_q)
      PS_IDLE: begin
        if (start_i) begin
          req_d   = 1'b1;
          coin_d  = next_coin;
          timer_d = '0;
          state_d = PS_REQ;
        end
      end
      PS_REQ: begin
        if (pay_ack_i) begin
          paid_o  = 1'b1;
          req_d   = 1'b0;
          state_d = PS_GAP;
        end else if (timer_q == TMR_W'(ACK_TIMEOUT)) begin
          timeout_o = 1'b1;
          req_d     = 1'b0;
          coin_d    = '0;
          state_d   = PS_IDLE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      PS_GAP: begin
        // credit_i already reflects the coin just paid.
        if (credit_i >= MONEY_W'(COIN_5)) begin
          req_d   = 1'b1;
          coin_d  = next_coin;
          timer_d = '0;
          state_d = PS_REQ;
        end else begin
          done_o  = 1'b1;
          coin_d  = '0;
          state_d = PS_IDLE;
        end
      end
      default: state_d = PS_IDLE;
    endcase
  end

  assign pay_req_o  = req_q;
  assign pay_coin_o = coin_q;

endmodule

// File: rtl/vend_dispense_ctrl.sv
// vend_dispense_ctrl: vending machine transaction controller.
// Accumulates coin credit, arbitrates product button presses and change
// requests onto one dispenser and one coin-payout mechanism, tracks stock.
// Ports:
//   clk_i, rst_i            clock / asynchronous active-high reset
//   coin_valid_i/coin_val_i coin insertion pulse and value
//   buttom_i                product buttons (rising edge = request)
//   button_change_i         change button (rising edge = request)
//   refill_i                reload all stock (honoured in IDLE only)
//   disp_req_o/disp_sel_o   dispense request and product index
//   disp_ack_i              dispenser done pulse
//   pay_req_o/pay_coin_o    coin payout request and coin value
//   pay_ack_i               payout done pulse
//   credit_o                current credit
//   LED_o                   product available and affordable
//   stock_o                 packed per-product stock counts
//   busy_o                  transaction in progress
//   err_o                   one-cycle error pulse
module vend_dispense_ctrl
  import vend_pkg::*;
#(
  parameter int N_PROD      = N_PROD_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int MONEY_W     = MONEY_W_DEF,
  parameter int INIT_STOCK  = 7,
  parameter int ACK_TIMEOUT = 63
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    coin_valid_i,
  input  logic [MONEY_W-1:0]      coin_val_i,
  input  logic [N_PROD-1:0]       buttom_i,
  input  logic                    button_change_i,
  input  logic                    refill_i,
  output logic                    disp_req_o,
  output logic [2:0]              disp_sel_o,
  input  logic                    disp_ack_i,
  output logic                    pay_req_o,
  output logic [MONEY_W-1:0]      pay_coin_o,
  input  logic                    pay_ack_i,
  output logic [MONEY_W-1:0]      credit_o,
  output logic [N_PROD-1:0]       LED_o,
  output logic [N_PROD*CNT_W-1:0] stock_o,
  output logic                    busy_o,
  output logic                    err_o
);

  localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [MONEY_W:0] MONEY_MAX = {1'b0, {MONEY_W{1'b1}}};

  state_e             state_q, state_d;
  logic [MONEY_W-1:0] credit_q, credit_d;
  logic [CNT_W-1:0]   stock_q [N_PROD];
  logic [CNT_W-1:0]   stock_d [N_PROD];
  logic [N_PROD-1:0]  btn_prev_q;
  logic               chg_prev_q;
  logic [2:0]         sel_q, sel_d;
  logic               disp_req_q, disp_req_d;
  logic               err_q, err_d;
  logic [TMR_W-1:0]   timer_q, timer_d;

  logic [N_PROD-1:0]  btn_rise, led_w, cand;
  logic               chg_rise;
  logic               win_found;
  logic [2:0]         win_idx;
  logic [MONEY_W-1:0] refund;
  logic [MONEY_W:0]   credit_base, coin_total;
  logic               coin_ok;
  logic [MONEY_W-1:0] credit_sum;

  logic               pay_start, pay_paid, pay_done, pay_timeout;

  assign btn_rise = buttom_i & ~btn_prev_q;
  assign chg_rise = button_change_i & ~chg_prev_q;

  for (genvar gi = 0; gi < N_PROD; gi++) begin : g_prod
    assign led_w[gi] = (stock_q[gi] != '0) && (credit_q >= MONEY_W'(PRICE[gi]));
    assign stock_o[gi*CNT_W +: CNT_W] = stock_q[gi];
  end

  assign cand = btn_rise & led_w;

  // Lowest-index affordable, in-stock request wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = N_PROD - 1; i >= 0; i--) begin
      if (cand[i]) begin
        win_found = 1'b1;
        win_idx   = 3'(i);
      end
    end
  end

  // Credit path: a timed-out dispense refunds its price, and a coin is only
  // accepted if the total still fits in the credit register.
  always_comb begin
    refund = '0;
    if (state_q == ST_DISPENSE && !disp_ack_i && timer_q == TMR_W'(ACK_TIMEOUT)) begin
      refund = MONEY_W'(PRICE[sel_q]);
    end
    credit_base = {1'b0, credit_q} + {1'b0, refund};
    coin_total  = credit_base + {1'b0, coin_val_i};
    coin_ok     = coin_valid_i && (state_q != ST_PAYOUT) && (coin_total <= MONEY_MAX);
    credit_sum  = coin_ok ? coin_total[MONEY_W-1:0] : credit_base[MONEY_W-1:0];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      credit_q   <= '0;
      for (int i = 0; i < N_PROD; i++) stock_q[i] <= CNT_W'(INIT_STOCK);
      btn_prev_q <= '0;
      chg_prev_q <= 1'b0;
      sel_q      <= '0;
      disp_req_q <= 1'b0;
      err_q      <= 1'b0;
      timer_q    <= '0;
    end else begin
      state_q    <= state_d;
      credit_q   <= credit_d;
      stock_q    <= stock_d;
      btn_prev_q <= buttom_i;
      chg_prev_q <= button_change_i;
      sel_q      <= sel_d;
      disp_req_q <= disp_req_d;
      err_q      <= err_d;
      timer_q    <= timer_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    credit_d   = credit_sum;
    stock_d    = stock_q;
    sel_d      = sel_q;
    disp_req_d = disp_req_q;
    timer_d    = timer_q;
    pay_start  = 1'b0;
    // Rejected coins (overflow, or any coin during payout) flag an error.
    err_d      = coin_valid_i && !coin_ok;

    unique case (state_q)
      ST_IDLE: begin
        if (refill_i) begin
          for (int i = 0; i < N_PROD; i++) stock_d[i] = CNT_W'(INIT_STOCK);
        end
        if (win_found) begin
          credit_d   = credit_sum - MONEY_W'(PRICE[win_idx]);
          sel_d      = win_idx;
          disp_req_d = 1'b1;
          timer_d    = '0;
          state_d    = ST_DISPENSE;
        end else if (chg_rise) begin
          if (credit_q >= MONEY_W'(COIN_5)) begin
            pay_start = 1'b1;
            state_d   = ST_PAYOUT;
          end else begin
            // Too little to pay out: the remainder is forfeited.
            credit_d = coin_ok ? coin_val_i : '0;
            if (credit_q != '0) err_d = 1'b1;
          end
        end
      end
      ST_DISPENSE: begin
        if (disp_ack_i) begin
          stock_d[sel_q] = stock_q[sel_q] - CNT_W'(1);
          disp_req_d     = 1'b0;
          timer_d        = '0;
          state_d        = ST_IDLE;
        end else if (timer_q == TMR_W'(ACK_TIMEOUT)) begin
          disp_req_d = 1'b0;
          err_d      = 1'b1;
          timer_d    = '0;
          state_d    = ST_IDLE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      ST_PAYOUT: begin
        if (pay_paid) begin
          credit_d = credit_q - pay_coin_o;
        end else if (pay_done) begin
          credit_d = '0;
          if (credit_q != '0) err_d = 1'b1;
          state_d = ST_IDLE;
        end else if (pay_timeout) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  vend_payout_seq #(
    .MONEY_W    (MONEY_W),
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_payout (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start_i   (pay_start),
    .credit_i  (credit_q),
    .pay_ack_i (pay_ack_i),
    .pay_req_o (pay_req_o),
    .pay_coin_o(pay_coin_o),
    .paid_o    (pay_paid),
    .done_o    (pay_done),
    .timeout_o (pay_timeout)
  );

  assign disp_req_o = disp_req_q;
  assign disp_sel_o = sel_q;
  assign credit_o   = credit_q;
  assign LED_o      = led_w;
  assign busy_o     = (state_q != ST_IDLE);
  assign err_o      = err_q;

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// Self-checking bench for vend_dispense_ctrl: table-driven purchase vectors
// plus hand-written sequences for payout, stock exhaustion, timeout,
// credit overflow and reset during payout.
module tb_vend_dispense_ctrl;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        coin_valid_i;
  logic [7:0]  coin_val_i;
  logic [5:0]  buttom_i;
  logic        button_change_i;
  logic        refill_i;
  logic        disp_req_o;
  logic [2:0]  disp_sel_o;
  logic        disp_ack_i;
  logic        pay_req_o;
  logic [7:0]  pay_coin_o;
  logic        pay_ack_i;
  logic [7:0]  credit_o;
  logic [5:0]  LED_o;
  logic [17:0] stock_o;
  logic        busy_o;
  logic        err_o;

  always #5 clk = ~clk;

  vend_dispense_ctrl dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .coin_valid_i   (coin_valid_i),
    .coin_val_i     (coin_val_i),
    .buttom_i       (buttom_i),
    .button_change_i(button_change_i),
    .refill_i       (refill_i),
    .disp_req_o     (disp_req_o),
    .disp_sel_o     (disp_sel_o),
    .disp_ack_i     (disp_ack_i),
    .pay_req_o      (pay_req_o),
    .pay_coin_o     (pay_coin_o),
    .pay_ack_i      (pay_ack_i),
    .credit_o       (credit_o),
    .LED_o          (LED_o),
    .stock_o        (stock_o),
    .busy_o         (busy_o),
    .err_o          (err_o)
  );

  int checks   = 0;
  int failures = 0;
  int err_cnt  = 0;

  int price_m [6] = '{15, 15, 20, 25, 10, 35};
  int stock_m [6];

  typedef struct {
    int         coin_a;
    int         coin_b;
    logic [5:0] btn;
    bit         hit;
    int         sel;
    int         credit;
  } vec_t;
  vec_t vecs [8];

  typedef struct {
    int sel;
    int credit;
  } disp_exp_t;
  disp_exp_t disp_q [$];
  int        pay_q  [$];

  bit disp_auto = 1'b1;
  bit pay_auto  = 1'b1;
  int disp_cnt  = 0;
  int pay_cnt   = 0;
  logic disp_req_prev = 1'b0;
  logic pay_req_prev  = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Dispenser / payout responders: ack after the request has been seen for 3 cycles.
  always @(negedge clk) begin
    disp_ack_i = 1'b0;
    pay_ack_i  = 1'b0;
    if (disp_auto && disp_req_o) begin
      disp_cnt++;
      if (disp_cnt == 3) begin disp_ack_i = 1'b1; disp_cnt = 0; end
    end else disp_cnt = 0;
    if (pay_auto && pay_req_o) begin
      pay_cnt++;
      if (pay_cnt == 3) begin pay_ack_i = 1'b1; pay_cnt = 0; end
    end else pay_cnt = 0;
  end

  // Scoreboard monitors: each new request is matched against the queued expectation.
  always @(negedge clk) begin
    if (err_o) err_cnt++;
    if (disp_req_o && !disp_req_prev) begin
      $display("dispense sel=%0d credit=%0d", disp_sel_o, credit_o);
      if (disp_q.size() == 0) check("unexpected_dispense", int'(disp_sel_o), -1);
      else begin
        disp_exp_t e;
        e = disp_q.pop_front();
        check("disp_sel", int'(disp_sel_o), e.sel);
        check("disp_credit", int'(credit_o), e.credit);
      end
    end
    if (pay_req_o && !pay_req_prev) begin
      $display("payout coin=%0d credit=%0d", pay_coin_o, credit_o);
      if (pay_q.size() == 0) check("unexpected_payout", int'(pay_coin_o), -1);
      else check("pay_coin", int'(pay_coin_o), pay_q.pop_front());
    end
    disp_req_prev = disp_req_o;
    pay_req_prev  = pay_req_o;
  end

  task automatic settle();
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic insert_coin(input int v);
    @(negedge clk);
    coin_valid_i = 1'b1;
    coin_val_i   = 8'(v);
    @(negedge clk);
    coin_valid_i = 1'b0;
    coin_val_i   = '0;
  endtask

  task automatic press(input logic [5:0] b);
    @(negedge clk);
    buttom_i = b;
    @(negedge clk);
    buttom_i = '0;
  endtask

  task automatic press_change();
    @(negedge clk);
    button_change_i = 1'b1;
    @(negedge clk);
    button_change_i = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (!busy_o) break;
    end
    check("idle_reached", int'(busy_o), 0);
  endtask

  function automatic int stock_of(input int i);
    return int'((stock_o >> (i * 3)) & 18'h7);
  endfunction

  function automatic logic [5:0] led_model(input int credit);
    logic [5:0] l;
    for (int i = 0; i < 6; i++) l[i] = (stock_m[i] != 0) && (credit >= price_m[i]);
    return l;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int e0;
    int hold;
    vecs[0] = '{10, 5,  6'b000001, 1'b1, 0, 0};
    vecs[1] = '{20, 20, 6'b010001, 1'b1, 0, 25};
    vecs[2] = '{0,  0,  6'b001000, 1'b1, 3, 0};
    vecs[3] = '{20, 0,  6'b100100, 1'b1, 2, 0};
    vecs[4] = '{10, 0,  6'b100000, 1'b0, 0, 10};
    vecs[5] = '{5,  20, 6'b100000, 1'b1, 5, 0};
    vecs[6] = '{10, 0,  6'b010000, 1'b1, 4, 0};
    vecs[7] = '{20, 0,  6'b000010, 1'b1, 1, 5};
    for (int i = 0; i < 6; i++) stock_m[i] = 7;

    rst_i = 1'b1; coin_valid_i = 1'b0; coin_val_i = '0; buttom_i = '0;
    button_change_i = 1'b0; refill_i = 1'b0; disp_ack_i = 1'b0; pay_ack_i = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_disp_req", int'(disp_req_o), 0);
    check("rst_disp_sel", int'(disp_sel_o), 0);
    check("rst_pay_req", int'(pay_req_o), 0);
    check("rst_pay_coin", int'(pay_coin_o), 0);
    check("rst_credit", int'(credit_o), 0);
    check("rst_led", int'(LED_o), 0);
    check("rst_err", int'(err_o), 0);
    check("rst_stock", int'(stock_o), int'({6{3'd7}}));
    rst_i = 1'b0;

    // Table-driven purchases.
    foreach (vecs[v]) begin
      if (vecs[v].coin_a != 0) insert_coin(vecs[v].coin_a);
      if (vecs[v].coin_b != 0) insert_coin(vecs[v].coin_b);
      if (vecs[v].hit) begin
        disp_q.push_back('{vecs[v].sel, vecs[v].credit});
        stock_m[vecs[v].sel]--;
      end
      press(vecs[v].btn);
      wait_idle(200);
      settle();
      check($sformatf("vec%0d_credit", v), int'(credit_o), vecs[v].credit);
      check($sformatf("vec%0d_drained", v), disp_q.size(), 0);
      if (vecs[v].hit)
        check($sformatf("vec%0d_stock", v), stock_of(vecs[v].sel), stock_m[vecs[v].sel]);
    end

    // Exhaust Cola stock.
    while (stock_m[0] > 0) begin
      insert_coin(10);
      insert_coin(5);
      disp_q.push_back('{0, 5});
      stock_m[0]--;
      press(6'b000001);
      wait_idle(200);
      settle();
    end
    check("cola_stock_zero", stock_of(0), 0);
    insert_coin(10);
    settle();
    check("led_cola_empty", int'(LED_o), int'(led_model(15)));
    press(6'b000001);
    settle();
    check("empty_press_busy", int'(busy_o), 0);
    check("empty_press_credit", int'(credit_o), 15);
    check("empty_press_nodisp", disp_q.size(), 0);
    @(negedge clk); refill_i = 1'b1;
    @(negedge clk); refill_i = 1'b0;
    for (int i = 0; i < 6; i++) stock_m[i] = 7;
    settle();
    check("refill_stock", int'(stock_o), int'({6{3'd7}}));
    check("refill_led", int'(LED_o), int'(led_model(15)));
    pay_q.push_back(10); pay_q.push_back(5);
    press_change();
    wait_idle(400);
    settle();
    check("change15_credit", int'(credit_o), 0);
    check("change15_drained", pay_q.size(), 0);

    // Dispense acknowledgement timeout.
    insert_coin(20); insert_coin(10); insert_coin(5);
    disp_auto = 1'b0;
    disp_q.push_back('{5, 0});
    e0 = err_cnt;
    @(negedge clk);
    buttom_i = 6'b100000;
    hold = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      buttom_i = '0;
      if (disp_req_o) hold++;
      else if (hold > 0) break;
    end
    check("timeout_hold", hold, 64);
    settle();
    disp_auto = 1'b1;
    check("timeout_err", err_cnt - e0, 1);
    check("timeout_credit", int'(credit_o), 35);
    check("timeout_stock5", stock_of(5), 7);
    check("timeout_busy", int'(busy_o), 0);
    pay_q.push_back(20); pay_q.push_back(10); pay_q.push_back(5);
    e0 = err_cnt;
    press_change();
    wait_idle(400);
    settle();
    check("change35_credit", int'(credit_o), 0);
    check("change35_err", err_cnt - e0, 0);

    // Payout of 55 and credit overflow boundary.
    insert_coin(20); insert_coin(20); insert_coin(10); insert_coin(5);
    pay_q.push_back(20); pay_q.push_back(20); pay_q.push_back(10); pay_q.push_back(5);
    press_change();
    wait_idle(400);
    settle();
    check("change55_credit", int'(credit_o), 0);
    check("change55_drained", pay_q.size(), 0);
    e0 = err_cnt;
    repeat (25) insert_coin(10);
    settle();
    check("credit_250", int'(credit_o), 250);
    check("credit_250_err", err_cnt - e0, 0);
    insert_coin(10);
    settle();
    check("overflow_err", err_cnt - e0, 1);
    check("overflow_credit", int'(credit_o), 250);
    insert_coin(5);
    settle();
    check("credit_255", int'(credit_o), 255);
    check("credit_255_err", err_cnt - e0, 1);
    check("led_all", int'(LED_o), 6'h3f);
    insert_coin(5);
    settle();
    check("overflow255_err", err_cnt - e0, 2);
    check("overflow255_credit", int'(credit_o), 255);

    // Reset in the middle of a payout.
    pay_auto = 1'b0;
    pay_q.push_back(20);
    press_change();
    repeat (3) @(negedge clk);
    check("payout_req", int'(pay_req_o), 1);
    check("payout_busy", int'(busy_o), 1);
    e0 = err_cnt;
    insert_coin(10);
    settle();
    check("payout_coin_err", err_cnt - e0, 1);
    check("payout_coin_credit", int'(credit_o), 255);
    @(negedge clk);
    #2 rst_i = 1'b1;
    #1;
    check("midrst_pay_req", int'(pay_req_o), 0);
    check("midrst_pay_coin", int'(pay_coin_o), 0);
    check("midrst_credit", int'(credit_o), 0);
    check("midrst_busy", int'(busy_o), 0);
    check("midrst_led", int'(LED_o), 0);
    check("midrst_disp_req", int'(disp_req_o), 0);
    @(negedge clk);
    rst_i = 1'b0;
    pay_auto = 1'b1;

    // Change with credit below the smallest coin forfeits it.
    insert_coin(3);
    settle();
    check("small_credit", int'(credit_o), 3);
    e0 = err_cnt;
    press_change();
    settle();
    check("small_change_credit", int'(credit_o), 0);
    check("small_change_err", err_cnt - e0, 1);
    check("small_change_busy", int'(busy_o), 0);

    check("final_disp_q", disp_q.size(), 0);
    check("final_pay_q", pay_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vend_dispense_ctrl.md
Name: vend_dispense_ctrl

Overview:
Transaction controller for the six-product coin vending machine. It accumulates inserted credit and arbitrates product-button presses and change requests onto one shared dispense mechanism and one coin-payout mechanism, using req/ack handshakes. It also tracks per-product stock. It sits between the coin acceptor / front panel and the dispense and payout actuators.

Parameters:
N_PROD, 6, number of products (index 0..5: Cola, Pepsi, Sitro, Milk, Water, Tomatos)
CNT_W, 3, stock counter width per product
MONEY_W, 8, credit and coin value width
INIT_STOCK, 7, stock value loaded at reset and on refill
ACK_TIMEOUT, 63, maximum cycles to wait for disp_ack_i or pay_ack_i

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous active-high reset
coin_valid_i  in  1  one-cycle pulse: coin inserted
coin_val_i  in  MONEY_W  inserted coin value, valid with coin_valid_i
buttom_i  in  N_PROD  product buttons, level; rising edge = request
button_change_i  in  1  change button, level; rising edge = request
refill_i  in  1  reload all stock to INIT_STOCK
disp_req_o  out  1  dispense request, held until ack or timeout
disp_sel_o  out  3  product index being dispensed
disp_ack_i  in  1  dispenser done, one-cycle pulse
pay_req_o  out  1  coin payout request
pay_coin_o  out  MONEY_W  coin value to pay (20, 10 or 5)
pay_ack_i  in  1  payout done, one-cycle pulse
credit_o  out  MONEY_W  current credit
LED_o  out  N_PROD  bit i = stock[i]!=0 and credit>=PRICE[i]
stock_o  out  N_PROD*CNT_W  packed stock counts, product i at [i*CNT_W +: CNT_W]
busy_o  out  1  state != IDLE
err_o  out  1  one-cycle error pulse

Behaviour:
- Reset (asynchronous): state=IDLE; credit=0; stock[i]=INIT_STOCK; edge-detect registers=0; timer=0.
- Reset outputs: disp_req_o=0, disp_sel_o=0, pay_req_o=0, pay_coin_o=0, err_o=0, LED_o=0.
- Reset mid-transaction aborts the transaction with no refund.
- Prices (package constants): 15, 15, 20, 25, 10, 35.
- Edge detect: rise = input & ~previous registered input, for buttom_i and button_change_i.
- Credit add: coin_valid_i in IDLE or DISPENSE adds coin_val_i.
  - If credit+coin > 255: coin rejected, credit unchanged, err_o pulse.
  - In PAYOUT, coins are rejected with an err_o pulse.
- IDLE:
  - Candidate set = rise & LED_o, evaluated on registered credit and stock.
  - Lowest-index candidate wins; all other rises are discarded.
  - On a winner: credit -= PRICE, disp_sel_o = index, disp_req_o=1 from the next edge, go to DISPENSE.
  - A coin add in the same cycle is also applied: credit' = credit + coin - price.
  - A rise on a non-affordable or empty product is ignored, with no error.
  - If there is no product winner, change rise and credit>=5: go to PAYOUT. A product request has priority over change in the same cycle.
  - Change rise with credit<5: credit cleared; err_o pulses if credit was nonzero.
  - refill_i is acted on only in IDLE; it sets all stock to INIT_STOCK.
- DISPENSE:
  - On disp_ack_i: stock[sel] -= 1, disp_req_o=0, go to IDLE.
  - If the timer reaches ACK_TIMEOUT: price refunded to credit, stock unchanged, err_o pulse, go to IDLE.
  - Button and change rises during DISPENSE are ignored.
- PAYOUT (greedy):
  - pay_coin_o = largest of {20,10,5} that is <= credit; pay_req_o=1.
  - On pay_ack_i: credit -= coin and pay_req_o=0 for one cycle.
  - Then, if credit>=5, the next coin is requested. Otherwise the remainder is cleared (err_o pulse if remainder !=0) and the state goes to IDLE.
  - On timeout: pay_req_o=0, credit kept, err_o pulse, go to IDLE.
- Timer: cleared on each state entry and each new request; counts every cycle while a request is pending.
- Stock never underflows, because a product with stock 0 is never a candidate.
- busy_o and LED_o are combinational from registered state.

Decomposition:
- Package vend_pkg holds: PRICE array, product index constants, coin denominations {20,10,5}, state enum {IDLE, DISPENSE, PAYOUT}, MONEY_W/CNT_W defaults.
- One sub-module, vend_payout_seq: a greedy coin selector plus pay_req/pay_ack handshake and timeout. It is started by the main FSM and returns done or timeout.

Test Plan:
- Coins 10+5 (credit 15), press buttom_i[0] -> disp_req_o=1, disp_sel_o=0, credit 0. On ack, stock_o[2:0]=6.
- Credit 40, press buttom_i[0] and [4] in the same cycle -> product 0 served, credit 25. Press [3] -> served, credit 0.
- Credit 55, change rise -> pay_coin_o sequence 20,20,10,5; credit 0; back to IDLE.
- Dispense 7 Colas with refills withheld -> stock 0, LED_o[0]=0, and the 8th press is ignored. refill_i -> stock 7.
- Credit 35, press [5], disp_ack_i withheld 64 cycles -> err_o pulse, credit 35, stock[5]=7.
- Credit 250, insert 10 -> rejected, err_o pulse, credit 250. Assert rst_i mid-PAYOUT -> all outputs 0, credit 0.
